ascii_encoder: RTL and testbench

ASCII_ENCODER -- requirements
Module: ascii_encoder

---
 rtl/encoder_pkg.sv | 24 ++
 rtl/ascii_encoder_bin2ascii2.sv | 29 ++
 rtl/ascii_encoder.sv | 147 ++++++++++++++
 tb/tb_ascii_encoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the ASCII time-report encoder: FSM encoding,
// frame length, field range limits and ASCII character constants.
package encoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } stateT;

  localparam int FRAME_LEN = 11;
  localparam logic [3:0] LAST_INDEX = 4'(FRAME_LEN - 1);

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] DASH  = 8'h2D;

endpackage

// File: rtl/ascii_encoder_bin2ascii2.sv
// Converts a 6-bit binary field into two ASCII decimal digits, most
// significant first, or "--" when the value exceeds its range limit.
module bin2ascii2
  import encoder_pkg::*;
(
  input  logic [5:0] value,
  input  logic [5:0] limit,
  output logic [7:0] tens,
  output logic [7:0] ones
);

  logic [5:0] tensDigit;
  logic [5:0] onesDigit;

  // Split the value into decimal digits and map them to ASCII, or dashes
  // when the field is out of range.
  always_comb begin
    tensDigit = value / 6'd10;
    onesDigit = value % 6'd10;
    if (value > limit) begin
      tens = DASH;
      ones = DASH;
    end else begin
      tens = ZERO + {2'b00, tensDigit};
      ones = ZERO + {2'b00, onesDigit};
    end
  end

endmodule

// File: rtl/ascii_encoder.sv
// Emits one 11-byte ASCII time report "T HH:MM:SS CR LF" into a UART TX
// FIFO per start request, stalling cleanly while the FIFO is full.
module ascii_encoder
  import encoder_pkg::*;
(
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic [7:0] iTag,
  input  logic [4:0] iHour,
  input  logic [5:0] iMin,
  input  logic [5:0] iSec,
  input  logic       iFull,
  output logic [7:0] oData,
  output logic       oPush,
  output logic       oBusy,
  output logic       oDone
);

  stateT state;
  stateT stateNext;

  logic [7:0] tagQ;
  logic [4:0] hourQ;
  logic [5:0] minQ;
  logic [5:0] secQ;

  logic [7:0] h1, h0, m1, m0, s1, s0;
  logic [7:0] h1Q, h0Q, m1Q, m0Q, s1Q, s0Q;

  logic [3:0] index;
  logic [7:0] frameByte;

  bin2ascii2 hourConv (
    .value ({1'b0, hourQ}),
    .limit (HOUR_MAX),
    .tens  (h1),
    .ones  (h0)
  );

  bin2ascii2 minConv (
    .value (minQ),
    .limit (MINSEC_MAX),
    .tens  (m1),
    .ones  (m0)
  );

  bin2ascii2 secConv (
    .value (secQ),
    .limit (MINSEC_MAX),
    .tens  (s1),
    .ones  (s0)
  );

  // FSM state register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state and output decode; push is gated directly by the FIFO flag.
  always_comb begin
    stateNext = state;
    oPush     = 1'b0;
    oBusy     = 1'b1;
    oDone     = 1'b0;
    oData     = 8'h00;
    case (state)
      IDLE: begin
        oBusy = 1'b0;
        if (iStart) stateNext = LOAD;
      end
      LOAD: stateNext = SEND;
      SEND: begin
        oPush = !iFull;
        oData = frameByte;
        if (!iFull && index == LAST_INDEX) stateNext = DONE;
      end
      DONE: begin
        oDone     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Snapshot the inputs on an accepted start so later changes cannot leak in.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      tagQ  <= 8'h00;
      hourQ <= 5'd0;
      minQ  <= 6'd0;
      secQ  <= 6'd0;
    end else if (state == IDLE && iStart) begin
      tagQ  <= iTag;
      hourQ <= iHour;
      minQ  <= iMin;
      secQ  <= iSec;
    end
  end

  // Register the converted digit characters during the LOAD cycle.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      h1Q <= 8'h00;
      h0Q <= 8'h00;
      m1Q <= 8'h00;
      m0Q <= 8'h00;
      s1Q <= 8'h00;
      s0Q <= 8'h00;
    end else if (state == LOAD) begin
      h1Q <= h1;
      h0Q <= h0;
      m1Q <= m1;
      m0Q <= m0;
      s1Q <= s1;
      s0Q <= s0;
    end
  end

  // Byte index: cleared in LOAD, advanced only on an accepted push.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)                          index <= 4'd0;
    else if (state == LOAD)            index <= 4'd0;
    else if (state == SEND && !iFull)  index <= index + 4'd1;
  end

  // Select the frame byte at the current index.
  always_comb begin
    frameByte = 8'h00;
    case (index)
      4'd0:    frameByte = tagQ;
      4'd1:    frameByte = h1Q;
      4'd2:    frameByte = h0Q;
      4'd3:    frameByte = COLON;
      4'd4:    frameByte = m1Q;
      4'd5:    frameByte = m0Q;
      4'd6:    frameByte = COLON;
      4'd7:    frameByte = s1Q;
      4'd8:    frameByte = s0Q;
      4'd9:    frameByte = CR;
      4'd10:   frameByte = LF;
      default: frameByte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ascii_encoder.sv
// Self-checking bench for ascii_encoder: directed cases plus random frames
// compared against a frame model built from the text format rules.
module tb_ascii_encoder;

  logic       iClk;
  logic       iRst;
  logic       iStart;
  logic [7:0] iTag;
  logic [4:0] iHour;
  logic [5:0] iMin;
  logic [5:0] iSec;
  logic       iFull;
  logic [7:0] oData;
  logic       oPush;
  logic       oBusy;
  logic       oDone;

  int checks = 0;
  int errors = 0;

  ascii_encoder dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (iStart),
    .iTag   (iTag),
    .iHour  (iHour),
    .iMin   (iMin),
    .iSec   (iSec),
    .iFull  (iFull),
    .oData  (oData),
    .oPush  (oPush),
    .oBusy  (oBusy),
    .oDone  (oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Two ASCII characters for one field: decimal with leading zero, or dashes.
  function automatic logic [15:0] fieldText(input int v, input int maxVal);
    if (v > maxVal) return {8'h2D, 8'h2D};
    return {8'(8'h30 + v / 10), 8'(8'h30 + v % 10)};
  endfunction

  task automatic buildFrame(input logic [7:0] tag, input int h, input int m, input int s,
                            output logic [7:0] frame [11]);
    logic [15:0] hf, mf, sf;
    hf = fieldText(h, 23);
    mf = fieldText(m, 59);
    sf = fieldText(s, 59);
    frame[0]  = tag;
    frame[1]  = hf[15:8];
    frame[2]  = hf[7:0];
    frame[3]  = 8'h3A;
    frame[4]  = mf[15:8];
    frame[5]  = mf[7:0];
    frame[6]  = 8'h3A;
    frame[7]  = sf[15:8];
    frame[8]  = sf[7:0];
    frame[9]  = 8'h0D;
    frame[10] = 8'h0A;
  endtask

  // Issue one start and follow the frame cycle by cycle. Optional stall at
  // a byte index, a start pulse during SEND and an hour change after start.
  task automatic applyStimulus(input string name, input logic [7:0] tag, input int h,
                               input int m, input int s, input int stallAt,
                               input int stallLen, input bit pokeStart, input bit changeHour);
    logic [7:0] frame [11];
    int k, lastPush, firstPush, stallLeft, badData, badPush;
    buildFrame(tag, h, m, s, frame);
    @(negedge iClk);
    iTag = tag; iHour = 5'(h); iMin = 6'(m); iSec = 6'(s); iStart = 1'b1; iFull = 1'b0;
    @(negedge iClk);
    iStart = 1'b0;
    #1;
    checkOutput({name, " load busy"}, 32'(oBusy), 32'd1);
    checkOutput({name, " load push"}, 32'(oPush), 32'd0);
    @(negedge iClk);
    k = 0; lastPush = -1; firstPush = -1; stallLeft = stallLen; badData = 0; badPush = 0;
    for (int j = 1; j < 40 && k < 11; j++) begin
      iStart = (pokeStart && j == 4);
      if (changeHour && j == 2) iHour = 5'(h + 1);
      if (k == stallAt && stallLeft > 0) begin
        iFull = 1'b1;
        stallLeft--;
      end else begin
        iFull = 1'b0;
      end
      #1;
      if (oPush !== !iFull) badPush++;
      if (oData !== frame[k]) badData++;
      if (iFull && k == 4 && oData !== 8'h33 && h == 12 && m == 34) badData++;
      if (oPush === 1'b1) begin
        if (firstPush < 0) firstPush = j;
        lastPush = j;
        k++;
      end
      @(negedge iClk);
    end
    iStart = 1'b0;
    iFull = 1'b0;
    checkOutput({name, " bytes pushed"}, 32'(k), 32'd11);
    checkOutput({name, " data errs"}, 32'(badData), 32'd0);
    checkOutput({name, " push errs"}, 32'(badPush), 32'd0);
    checkOutput({name, " first push"}, 32'(firstPush), 32'd1);
    checkOutput({name, " last push"}, 32'(lastPush), 32'(11 + stallLen));
    #1;
    checkOutput({name, " done pulse"}, 32'(oDone), 32'd1);
    checkOutput({name, " done push"}, 32'(oPush), 32'd0);
    @(negedge iClk);
    #1;
    checkOutput({name, " done end"}, {oDone, oBusy}, 32'd0);
  endtask

  task automatic checkQuiet(input string name, input int cycles);
    int pushes;
    pushes = 0;
    for (int j = 0; j < cycles; j++) begin
      @(negedge iClk);
      #1;
      if (oPush !== 1'b0 || oBusy !== 1'b0) pushes++;
    end
    checkOutput({name, " quiet"}, 32'(pushes), 32'd0);
  endtask

  initial begin
    logic [7:0] tags [5];
    int pushes;
    tags = '{8'h43, 8'h57, 8'h54, 8'h55, 8'h44};
    iRst = 1'b1; iStart = 1'b0; iTag = 8'h00; iHour = 5'd0; iMin = 6'd0;
    iSec = 6'd0; iFull = 1'b0;
    #1;
    checkOutput("reset outputs", {oData, oPush, oBusy, oDone}, 32'd0);
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    checkQuiet("post reset", 3);

    applyStimulus("case1", 8'h43, 12, 34, 56, -1, 0, 1'b0, 1'b0);
    applyStimulus("case2a", 8'h57, 0, 0, 9, -1, 0, 1'b0, 1'b0);
    applyStimulus("case2b", 8'h54, 23, 59, 59, -1, 0, 1'b0, 1'b0);
    applyStimulus("case3", 8'h55, 24, 60, 63, -1, 0, 1'b0, 1'b0);
    applyStimulus("case4", 8'h43, 12, 34, 56, 4, 5, 1'b0, 1'b0);
    applyStimulus("case5", 8'h44, 10, 20, 30, -1, 0, 1'b1, 1'b1);
    checkQuiet("case5 no queued", 15);

    // Case 6: abort mid-frame with reset after the fifth push.
    @(negedge iClk);
    iTag = 8'h43; iHour = 5'd12; iMin = 6'd34; iSec = 6'd56; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    pushes = 0;
    for (int j = 0; j < 20 && pushes < 5; j++) begin
      #1;
      if (oPush === 1'b1) pushes++;
      @(negedge iClk);
    end
    checkOutput("case6 pre-abort pushes", 32'(pushes), 32'd5);
    iRst = 1'b1;
    #1;
    checkOutput("case6 abort outputs", {oData, oPush, oBusy, oDone}, 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    checkQuiet("case6 after abort", 5);
    applyStimulus("case6 restart", 8'h57, 1, 2, 3, -1, 0, 1'b0, 1'b0);

    // Random frames, including out-of-range fields and random stalls.
    for (int r = 0; r < 6; r++) begin
      applyStimulus($sformatf("rand%0d", r), tags[$urandom_range(0, 4)],
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 63)), int'($urandom_range(0, 10)),
                    int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
